// File: rtl/decodificador_morse_if.sv
// rtl/decodificador_morse_if.sv - symbol input and decoded-digit output handshake bundle
interface decodificador_morse_if;
  logic       sym_valid;
  logic       sym;
  logic       sym_ready;
  logic       out_valid;
  logic       out_ack;
  logic [3:0] digit;
  logic [4:0] code;
  logic       err;

  modport master (
    output sym_valid, sym, out_ack,
    input  sym_ready, out_valid, digit, code, err
  );

  modport slave (
    input  sym_valid, sym, out_ack,
    output sym_ready, out_valid, digit, code, err
  );
endinterface

// File: rtl/decodificador_morse.sv
// rtl/decodificador_morse.sv - serial dot/dash to BCD digit decoder with idle timeout
module decodificador_morse #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  decodificador_morse_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

  localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [4:0] shreg;
  logic [2:0] cnt;
  logic [7:0] tmr;
  logic       xfer;
  logic [4:0] word;

  assign xfer = bus.sym_valid && bus.sym_ready;
  assign word = {shreg[3:0], bus.sym};

  // Returns {err, digit}; unknown patterns map to err=1, digit=F.
  function automatic logic [4:0] decode(input logic [4:0] c);
    case (c)
      5'b11111: decode = 5'h00;
      5'b01111: decode = 5'h01;
      5'b00111: decode = 5'h02;
      5'b00011: decode = 5'h03;
      5'b00001: decode = 5'h04;
      5'b00000: decode = 5'h05;
      5'b10000: decode = 5'h06;
      5'b11000: decode = 5'h07;
      5'b11100: decode = 5'h08;
      5'b11110: decode = 5'h09;
      default:  decode = 5'h1F;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      cnt           <= '0;
      tmr           <= '0;
      bus.sym_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.digit     <= '0;
      bus.code      <= '0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg <= word;
            cnt   <= 3'd1;
            tmr   <= '0;
            state <= RECV;
          end
        end

        RECV: begin
          if (xfer) begin
            shreg <= word;
            cnt   <= cnt + 3'd1;
            tmr   <= '0;
            if (cnt == 3'd4) begin
              state                  <= HOLD;
              bus.sym_ready          <= 1'b0;
              bus.out_valid          <= 1'b1;
              bus.code               <= word;
              {bus.err, bus.digit}   <= decode(word);
            end
          end else if (tmr == TMR_LAST) begin
            // shreg fills from bit 0 after being cleared, so a partial word is already right-aligned
            state         <= HOLD;
            bus.sym_ready <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.code      <= shreg;
            bus.digit     <= 4'hF;
            bus.err       <= 1'b1;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end

        HOLD: begin
          if (bus.out_ack) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.sym_ready <= 1'b1;
            shreg         <= '0;
            cnt           <= '0;
            tmr           <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/decodificador_morse.md
# decodificador_morse

Serial Morse-to-binary digit decoder: the receive-side counterpart of `codificador_em_morse`. It accepts a stream of dot/dash symbols one per handshake, assembles five symbols into a code word and decodes it to a 4-bit BCD digit (0–9). Invalid patterns and stalled characters are flagged. The block sits between a symbol slicer (or a loopback of the encoder's `s1` serialised MSB first) and the digit consumer.

## Interface

Parameters:
- `TIMEOUT`, default 16: idle cycles allowed between symbols of one character before the character is aborted; legal range 2–255.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `sym_valid` in 1: a symbol is presented on `sym`.
- `sym` in 1: symbol value; 1 = dash, 0 = dot.
- `sym_ready` out 1: the block accepts a symbol this cycle. A transfer occurs when `sym_valid && sym_ready`.
- `out_valid` out 1: decoded result pending; held until acknowledged.
- `out_ack` in 1: consumer takes the result.
- `digit` out 4: decoded digit; 4'hF on error.
- `code` out 5: raw received code word; first symbol in bit 4 (same layout as encoder `s1`).
- `err` out 1: result is invalid (unknown pattern or timeout).

## Operation

- Code table (`code` → `digit`): 11111→0, 01111→1, 00111→2, 00011→3, 00001→4, 00000→5, 10000→6, 11000→7, 11100→8, 11110→9. Any other 5-bit value → `digit`=4'hF, `err`=1.
- Internal state: 5-bit shift register `shreg`, 3-bit symbol count `cnt`, 8-bit idle timer `tmr`, and FSM state IDLE / RECV / HOLD.
- IDLE: `sym_ready`=1. On a transfer: `shreg` ← {`shreg`[3:0], `sym`}, `cnt`←1, `tmr`←0, go to RECV.
- RECV: `sym_ready`=1.
  - On a transfer: shift in the symbol, increment `cnt`, and clear `tmr`.
  - If that transfer is the 5th symbol, go to HOLD. Load `code` with the completed word, load `digit`/`err` from the table, and set `out_valid`.
  - With no transfer, `tmr` increments.
  - When `tmr` = `TIMEOUT`-1 and no transfer occurs, abort and go to HOLD:
    - `code` = received symbols right-aligned, upper bits 0;
    - `digit`=4'hF, `err`=1.
- HOLD: `sym_ready`=0 and `out_valid`=1, with outputs stable. On `out_ack`: clear `out_valid`, clear `shreg`/`cnt`/`tmr`, go to IDLE.
- `out_ack` outside HOLD is ignored.
- `sym_valid` while `sym_ready`=0 is not consumed. The upstream must hold it.

## Timing

- Reset values: `sym_ready`=1 (IDLE), `out_valid`=0, `digit`=0, `code`=0, `err`=0. All internal registers are 0.
- Latency: `out_valid` rises on the edge that accepts the 5th symbol, i.e. it is visible the cycle after that transfer. `sym_ready` falls in the same cycle.
- Back-to-back symbols (one per cycle) are supported. Five consecutive cycles produce the result on the 6th.
- Acknowledge: `out_ack` sampled high in HOLD means `out_valid`=0 and `sym_ready`=1 in the next cycle. A result can therefore be consumed every 6 cycles at best.
- A same-cycle `out_ack` and `sym_valid` in HOLD: the ack is honoured and the symbol is not accepted (`sym_ready` was 0).
- Timeout: with the last transfer at cycle t, abort happens on the edge at t+`TIMEOUT`. `out_valid` is then high in cycle t+`TIMEOUT`+1 (counting from the transfer edge).
- IDLE has no timeout. `tmr` only runs in RECV.
- `reset` in any state returns to reset values on the next edge and overrides a simultaneous transfer or ack.

## Test plan

- Reset, then feed digits 0–9 as 5 back-to-back symbols each, MSB first, with `out_ack` asserted one cycle after `out_valid`. Required: digit=0..9, `err`=0, `code` matches the table, `out_valid` high exactly the cycle after each 5th symbol.
- Send 01010. Required: `code`=01010, `digit`=4'hF, `err`=1.
- Send 3 dashes, then idle with `TIMEOUT`=16. Required: abort 16 cycles after the 3rd transfer, `code`=00111, `digit`=4'hF, `err`=1; no abort at 15 idle cycles.
- Hold `out_ack`=0 for 10 cycles with `sym_valid`=1 after a valid result. Required: `sym_ready`=0 and outputs stable throughout; the next symbol is accepted only the cycle after the ack.
- Assert `reset` after 2 symbols, then send 11110. Required: `digit`=9, `err`=0; no residue from the aborted character.
- Insert random 1–15-cycle gaps between symbols of "7" (11000) with `TIMEOUT`=16. Required: `digit`=7, no timeout.
